write_serial: RTL and testbench

WRITE_SERIAL -- requirements
Module: write_serial

---
 rtl/serial_pkg.sv | 14 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/write_serial.sv | 108 ++++++++++
 tb/tb_write_serial.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared serial-link definitions used by both the transmit and receive sides.
package serial_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned FRAME_BITS = 9;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head word is presented combinationally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/write_serial.sv
// Byte-buffered serial transmitter: start bit '0' then 8 data bits MSB first, back-to-back frames.
module write_serial
    import serial_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready,
    output logic              txd,
    output logic              busy
);

    tx_state_e         state;
    tx_state_e         state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_nxt;
    logic [BYTE_W-1:0] shift;
    logic [BYTE_W-1:0] shift_nxt;
    logic              txd_nxt;
    logic              busy_nxt;
    logic              pop;
    logic [BYTE_W-1:0] head;
    logic              full;
    logic              empty;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (valid_in),
        .wdata (data_in),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign ready = !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            txd     <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            txd     <= txd_nxt;
            busy    <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_nxt;
    end

    // txd/busy next values describe the bit that will be on the line after this edge.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        txd_nxt     = 1'b1;
        busy_nxt    = 1'b0;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = head;
                    state_nxt = START;
                    txd_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            START: begin
                state_nxt   = DATA;
                bit_cnt_nxt = CNT_W'(7);
                txd_nxt     = shift[BYTE_W-1];
                shift_nxt   = {shift[BYTE_W-2:0], 1'b0};
                busy_nxt    = 1'b1;
            end
            DATA: begin
                if (bit_cnt != '0) begin
                    bit_cnt_nxt = bit_cnt - CNT_W'(1);
                    txd_nxt     = shift[BYTE_W-1];
                    shift_nxt   = {shift[BYTE_W-2:0], 1'b0};
                    busy_nxt    = 1'b1;
                end else if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = head;
                    state_nxt = START;
                    txd_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_write_serial.sv
// Directed bench for write_serial with a line decoder that rebuilds bytes from txd.
module tb_write_serial;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready;
    logic       txd;
    logic       busy;

    int checks;
    int failures;

    logic [7:0] rx_q [$];
    int         busy_cycles;
    int         bitpos;
    logic [7:0] rx_sh;
    logic       mon_rst;

    write_serial #(.FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready    (ready),
        .txd      (txd),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line decoder: start bit is a '0' seen while not inside a frame.
    always @(posedge clk) begin
        mon_rst = reset;
        #1;
        if (mon_rst) begin
            bitpos = 0;
        end else begin
            if (busy) busy_cycles++;
            if (bitpos == 0) begin
                if (txd == 1'b0) bitpos = 1;
            end else begin
                rx_sh = {rx_sh[6:0], txd};
                if (bitpos == 8) begin
                    rx_q.push_back(rx_sh);
                    bitpos = 0;
                end else begin
                    bitpos++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        valid_in = 1'b0;
        step();
        reset = 1'b0;
        rx_q.delete();
        busy_cycles = 0;
    endtask

    task automatic wait_rx(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (rx_q.size() < n && c < budget) begin
            step();
            c++;
        end
        step();
        checks++;
        if (rx_q.size() != n) begin
            failures++;
            $display("FAIL %s rx_count got=%0d exp=%0d", name, rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        data_in = 8'hEE;
        do_reset();
        checks += 3;
        if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        if (txd   !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b exp=1", txd); end
        if (busy  !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (txd !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got txd=%b busy=%b exp txd=1 busy=0", i, txd, busy);
            end
        end
    endtask

    task automatic test_single_byte();
        logic [8:0] frame;
        frame = {1'b0, 8'hA5};
        do_reset();
        data_in  = 8'hA5;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_latency got txd=%b busy=%b exp txd=1 busy=0", txd, busy);
        end
        for (int i = 0; i < 9; i++) begin
            step();
            checks++;
            if (txd !== frame[8-i] || busy !== 1'b1) begin
                failures++;
                $display("FAIL single_bit%0d got txd=%b busy=%b exp txd=%b busy=1", i, txd, busy, frame[8-i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (txd !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL single_after%0d got txd=%b busy=%b exp txd=1 busy=0", i, txd, busy);
            end
        end
        checks += 2;
        if (busy_cycles != 9) begin failures++; $display("FAIL single_busy_cycles got=%0d exp=9", busy_cycles); end
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            failures++;
            $display("FAIL single_rx got_count=%0d exp_count=1 exp=a5", rx_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] frames;
        frames = {1'b0, 8'h00, 1'b0, 8'hFF};
        do_reset();
        data_in  = 8'h00;
        valid_in = 1'b1;
        step();
        data_in = 8'hFF;
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (txd !== frames[17-i] || busy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_bit%0d got txd=%b busy=%b exp txd=%b busy=1", i, txd, busy, frames[17-i]);
            end
            step();
        end
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got txd=%b busy=%b exp txd=1 busy=0", txd, busy);
        end
        step();
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF) begin
            failures++;
            $display("FAIL b2b_rx got_count=%0d exp_count=2", rx_q.size());
        end
    endtask

    task automatic test_full();
        int  k;
        int  first_low_k;
        logic acc;
        do_reset();
        k = 1;
        first_low_k = 0;
        data_in  = 8'd1;
        valid_in = 1'b1;
        for (int c = 0; c < 200 && k <= 6; c++) begin
            acc = ready;
            step();
            if (acc) begin
                k++;
                data_in = 8'(k);
            end else if (first_low_k == 0) begin
                first_low_k = k;
            end
        end
        valid_in = 1'b0;
        checks++;
        if (first_low_k != 6) begin
            failures++;
            $display("FAIL full_ready_drop got_at_byte=%0d exp_at_byte=6", first_low_k);
        end
        wait_rx(6, 120, "full");
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== 8'(i + 1)) begin
                failures++;
                $display("FAIL full_byte%0d got=%h exp=%h", i, rx_q[i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        do_reset();
        valid_in = 1'b1;
        data_in  = 8'h3C;
        step();
        data_in = 8'h11;
        step();
        data_in = 8'h22;
        step();
        valid_in = 1'b0;
        step();
        step();
        checks++;
        if (txd !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_4th_bit got txd=%b busy=%b exp txd=1 busy=1", txd, busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks += 3;
        if (txd !== 1'b1)   begin failures++; $display("FAIL midrst_txd got=%b exp=1", txd); end
        if (busy !== 1'b0)  begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ready); end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks += 2;
        if (bad != 0) begin failures++; $display("FAIL midrst_quiet got_active_cycles=%0d exp=0", bad); end
        if (rx_q.size() != 0) begin failures++; $display("FAIL midrst_rx got_count=%0d exp=0", rx_q.size()); end
    endtask

    task automatic test_loopback();
        logic [7:0] sent [$];
        int         mism;
        do_reset();
        for (int c = 0; c < 5000 && sent.size() < 64; c++) begin
            valid_in = ($urandom_range(0, 2) != 0);
            data_in  = 8'($urandom);
            if (valid_in && ready) sent.push_back(data_in);
            step();
        end
        valid_in = 1'b0;
        checks++;
        if (sent.size() != 64) begin failures++; $display("FAIL loop_sent got=%0d exp=64", sent.size()); end
        wait_rx(64, 700, "loop");
        mism = 0;
        for (int i = 0; i < sent.size() && i < rx_q.size(); i++) begin
            if (rx_q[i] !== sent[i]) mism++;
        end
        checks += 2;
        if (mism != 0) begin failures++; $display("FAIL loop_data got_mismatches=%0d exp=0", mism); end
        if (busy_cycles != 64 * 9) begin
            failures++;
            $display("FAIL loop_busy_cycles got=%0d exp=%0d", busy_cycles, 64 * 9);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        bitpos      = 0;
        busy_cycles = 0;
        rx_sh       = '0;
        reset       = 1'b1;
        valid_in    = 1'b0;
        data_in     = '0;
        step();
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_full();
        test_reset_mid_frame();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
